vic_mem_ctrl: RTL
=================

// Module: vic_mem_ctrl
// PURPOSE
//  Parametrised main-memory controller for the Vic datapath. It replaces inline
//  single-cycle memory with a single-port word array, a configurable read latency,
//  and arbitration between the word channel (MAR/MDR READ/WRITE) and the
//  byte-fetch channel (PC/MBR FETCH).
//  Sits between the microinstruction MEM field decode and the MDR/MBR registers.
// PARAMETERS
//  DATA_W   32  word width; MDR width
//  ADDR_W   8   word-address bits; array depth = 2**ADDR_W words
//  RD_LAT   1   read latency in cycles from issue to load strobe; legal 1..4
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  read_req   in   1       MEM.READ: word read at mar_addr
//  write_req  in   1       MEM.WRITE: word write of mdr_wdata at mar_addr
//  fetch_req  in   1       MEM.FETCH: byte read at pc_addr
//  mar_addr   in   32      word address (MAR)
//  mdr_wdata  in   DATA_W  write data (MDR)
//  pc_addr    in   32      byte address (PC)
//  mdr_rdata  out  DATA_W  read data for MDR; holds until next mdr_load
//  mdr_load   out  1       one-cycle strobe: MDR captures mdr_rdata
//  mbr_data   out  8       fetched byte for MBR; holds until next mbr_load
//  mbr_load   out  1       one-cycle strobe: MBR captures mbr_data
//  busy       out  1       controller cannot accept requests this cycle
//  addr_err   out  1       one-cycle pulse: out-of-range access
//  proto_err  out  1       one-cycle pulse: illegal request combination
// BEHAVIOUR
//  Reset: all outputs 0. Pending fetch and read pipelines cleared; in-flight loads
//   are dropped. Array contents are not cleared.
//  Acceptance: requests are sampled only when busy=0. Any request while busy=1 is
//   ignored and pulses proto_err on the next cycle.
//  Word address: mar_addr[ADDR_W-1:0]. Out of range if mar_addr[31:ADDR_W] != 0.
//  Fetch address: word pc_addr[ADDR_W+1:2], byte pc_addr[1:0], little-endian
//   (byte 0 = bits 7:0). Out of range if pc_addr[31:ADDR_W+2] != 0.
//  Single port: at most one array access (issue) per cycle.
//  Word ops:
//   - write_req: array updated at the end of the issue cycle. No load strobe.
//   - read_req: mdr_rdata/mdr_load valid exactly RD_LAT cycles after the issue cycle.
//   - read_req & write_req together: write performed, read dropped, proto_err
//     pulses next cycle.
//  Fetch op: mbr_data/mbr_load valid RD_LAT cycles after its issue cycle.
//  Arbitration:
//   - Word op and fetch_req in the same accepted cycle: the word op issues.
//   - pc_addr is captured into the pending-fetch register.
//   - busy=1 for exactly the next cycle; the pending fetch issues in that cycle.
//   - The fetch therefore loads RD_LAT+1 cycles after the request and observes
//     any write from the preceding cycle.
//  busy: equals pending-fetch valid; otherwise 0. No other stall sources.
//  Out of range:
//   - Write is suppressed.
//   - Read/fetch still strobes its load at normal latency with data 0.
//   - addr_err pulses coincident with the load strobe (write: cycle after issue).
//  Reads are pipelined: back-to-back issues each produce one strobe, in order.
//   mdr_load and mbr_load may assert in the same cycle.
//  Read-after-write, same address, consecutive cycles: the read returns the new data.
// TESTING
//  1 RD_LAT=1: write 0xDEADBEEF @MAR=5, then read @5 -> mdr_load 1 cycle after read,
//    mdr_rdata=0xDEADBEEF.
//  2 Word 0x44332211 @2; fetch PC=8..11 on consecutive cycles -> mbr_data
//    0x11, 0x22, 0x33, 0x44, one strobe each.
//  3 read@3 + fetch PC=0 same cycle -> busy=1 next cycle; mdr_load at +RD_LAT;
//    mbr_load at +RD_LAT+1.
//  4 RD_LAT=3: reads @1,@2,@3 back-to-back -> three strobes, cycles +3..+5, in order.
//  5 read with MAR=0x100 (ADDR_W=8) -> mdr_rdata=0, mdr_load=1, addr_err=1 same cycle.
//    Write to the same address -> array unchanged.
//  6 read+write same cycle -> proto_err, write lands, no mdr_load.
//    Reset asserted during an RD_LAT=3 read -> no strobe, all outputs 0.

Source files
------------

// File: rtl/vic_mem_ctrl.sv
// vic_mem_ctrl: single-port word memory for the Vic datapath; arbitrates MAR/MDR word read/write against PC/MBR byte fetch with RD_LAT-cycle load strobes, busy stall and addr/proto error pulses
module vic_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read_req,
  input  logic              write_req,
  input  logic              fetch_req,
  input  logic [31:0]       mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic [31:0]       pc_addr,
  output logic [DATA_W-1:0] mdr_rdata,
  output logic              mdr_load,
  output logic [7:0]        mbr_data,
  output logic              mbr_load,
  output logic              busy,
  output logic              addr_err,
  output logic              proto_err
);
  localparam int L = RD_LAT - 1;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic pf_v_q, pf_v_d;
  logic [31:0] pf_a_q, pf_a_d;
  logic [RD_LAT-1:0] p_v_q, p_v_d, p_f_q, p_f_d, p_e_q, p_e_d;
  logic [RD_LAT-1:0][DATA_W-1:0] p_d_q, p_d_d;
  logic [DATA_W-1:0] mdr_h_q, mdr_h_d;
  logic [7:0] mbr_h_q, mbr_h_d;
  logic perr_q, perr_d, werr_q, werr_d;
  logic acc, word_op, word_wr, word_rd, fetch_now, m_oor, f_oor;
  logic [31:0] f_addr;
  logic [DATA_W-1:0] f_word, iss_d;
  logic [7:0] f_byte;
  always_comb begin
    acc       = !pf_v_q;
    word_op   = acc & (read_req | write_req);
    word_wr   = acc & write_req;
    word_rd   = acc & read_req & !write_req;
    fetch_now = pf_v_q | (acc & fetch_req & !word_op);
    f_addr    = pf_v_q ? pf_a_q : pc_addr;
    m_oor     = |(mar_addr >> ADDR_W);
    f_oor     = |(f_addr >> (ADDR_W + 2));
    f_word    = mem[f_addr[ADDR_W+1:2]];
    f_byte    = f_word[{f_addr[1:0], 3'b000} +: 8];
    iss_d     = fetch_now ? (f_oor ? '0 : DATA_W'(f_byte)) : (m_oor ? '0 : mem[mar_addr[ADDR_W-1:0]]);
    pf_v_d    = acc & fetch_req & word_op;
    pf_a_d    = pf_v_d ? pc_addr : pf_a_q;
    perr_d    = (pf_v_q & (read_req | write_req | fetch_req)) | (acc & read_req & write_req);
    werr_d    = word_wr & m_oor;
    p_v_d     = RD_LAT'({p_v_q, word_rd | fetch_now});
    p_f_d     = RD_LAT'({p_f_q, fetch_now});
    p_e_d     = RD_LAT'({p_e_q, fetch_now ? f_oor : m_oor});
    p_d_d     = (RD_LAT*DATA_W)'({p_d_q, iss_d});
    mdr_load  = p_v_q[L] & !p_f_q[L];
    mbr_load  = p_v_q[L] & p_f_q[L];
    mdr_rdata = mdr_load ? p_d_q[L] : mdr_h_q;
    mbr_data  = mbr_load ? p_d_q[L][7:0] : mbr_h_q;
    mdr_h_d   = mdr_rdata;
    mbr_h_d   = mbr_data;
    busy      = pf_v_q;
    addr_err  = werr_q | (p_v_q[L] & p_e_q[L]);
    proto_err = perr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pf_v_q  <= 1'b0;
      pf_a_q  <= '0;
      p_v_q   <= '0;
      p_f_q   <= '0;
      p_e_q   <= '0;
      p_d_q   <= '0;
      mdr_h_q <= '0;
      mbr_h_q <= '0;
      perr_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      pf_v_q  <= pf_v_d;
      pf_a_q  <= pf_a_d;
      p_v_q   <= p_v_d;
      p_f_q   <= p_f_d;
      p_e_q   <= p_e_d;
      p_d_q   <= p_d_d;
      mdr_h_q <= mdr_h_d;
      mbr_h_q <= mbr_h_d;
      perr_q  <= perr_d;
      werr_q  <= werr_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && word_wr && !m_oor) mem[mar_addr[ADDR_W-1:0]] <= mdr_wdata;
  end
endmodule
